// File: rtl/uvme_apb_st_arb_if.sv
// Signal bundle between the two requesters, the arbiter and the APB completer.
// The arbiter uses the master modport; the requester/completer side uses slave.
interface uvme_apb_st_arb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_gnt;
    logic                  rsp0_valid;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_gnt;
    logic                  rsp1_valid;

    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    logic                  busy;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_gnt, req1_gnt, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr,
        output busy
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_gnt, req1_gnt, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr,
        input  busy
    );
endinterface

// File: rtl/uvme_apb_st_arb.sv
// Two-requester round-robin arbiter driving a single APB master port, with
// wait-state counting, optional timeout and a one-cycle completion pulse.
module uvme_apb_st_arb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    uvme_apb_st_arb_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [15:0]           wait_cnt_q;
    logic                  last_gnt_q;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  idle_ok;
    logic                  gnt0;
    logic                  gnt1;

    // Grants are combinational but forced low while reset is held, so the first
    // grant edge can only be a rising edge with reset_n already released.
    assign idle_ok = reset_n && (state_q == ST_IDLE);
    assign gnt0    = idle_ok && bus.req0_valid && (!bus.req1_valid ||  last_gnt_q);
    assign gnt1    = idle_ok && bus.req1_valid && (!bus.req0_valid || !last_gnt_q);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, whatever order the statements run in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
            last_gnt_q  <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // Completion fields are a one-cycle pulse; only an ACCESS exit sets them.
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        state_q    <= ST_SETUP;
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        wait_cnt_q <= '0;
                        last_gnt_q <= gnt1;
                        pwrite_q   <= gnt1 ? bus.req1_write : bus.req0_write;
                        paddr_q    <= gnt1 ? bus.req1_addr  : bus.req0_addr;
                        pwdata_q   <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
                    end
                end

                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end

                ST_ACCESS: begin
                    if (bus.pready) begin
                        state_q                 <= ST_IDLE;
                        psel_q                  <= 1'b0;
                        penable_q               <= 1'b0;
                        rsp_valid_q[last_gnt_q] <= 1'b1;
                        rsp_rdata_q             <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q               <= bus.pslverr;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                        if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST)) begin
                            state_q                 <= ST_IDLE;
                            psel_q                  <= 1'b0;
                            penable_q               <= 1'b0;
                            rsp_valid_q[last_gnt_q] <= 1'b1;
                            rsp_err_q               <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_gnt   = gnt0;
    assign bus.req1_gnt   = gnt1;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uvme_apb_st_arb.sv
// Self-checking bench for uvme_apb_st_arb: directed scenarios plus randomized
// transfers, each compared against a transaction-level model of the arbiter.
module tb_uvme_apb_st_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   model_last;   // requester granted most recently (1 after reset)

    uvme_apb_st_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    uvme_apb_st_arb #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer. Entered in an IDLE cycle with the requester inputs
    // already driven; returns in the completion cycle (which is IDLE again).
    // The completer inserts `waits` not-ready ACCESS cycles before pready.
    task automatic run_xfer(input int waits, input logic slverr, input logic [DW-1:0] rd_val,
                            input bit keep_valid, input string tag);
        int              win;
        int              n_acc;
        bit              to;
        logic [AW+DW:0]  exp_f;
        logic [AW+DW:0]  got_f;
        logic [DW-1:0]   exp_rdata;
        logic            exp_err;
        logic [1:0]      exp_rsp;
        logic [4:0]      got_ctl;

        if (bus.req0_valid && bus.req1_valid) win = (model_last == 0) ? 1 : 0;
        else                                  win = bus.req0_valid ? 0 : 1;
        exp_f = (win == 1) ? {bus.req1_write, bus.req1_addr, bus.req1_wdata}
                           : {bus.req0_write, bus.req0_addr, bus.req0_wdata};
        to        = (TO != 0) && (waits >= int'(TO));
        n_acc     = to ? int'(TO) : waits + 1;
        exp_err   = to ? 1'b1 : slverr;
        exp_rdata = (to || exp_f[AW+DW]) ? '0 : rd_val;
        exp_rsp   = (win == 1) ? 2'b10 : 2'b01;

        #1;
        checks++;
        if ({bus.req1_gnt, bus.req0_gnt} !== exp_rsp) begin
            failures++;
            $display("FAIL %s grant: got gnt1,gnt0=%b expected %b", tag,
                     {bus.req1_gnt, bus.req0_gnt}, exp_rsp);
        end
        model_last = win;

        step();  // SETUP: requester moves on, fields must not follow it
        if (win == 1) begin
            bus.req1_valid = keep_valid; bus.req1_addr = $urandom; bus.req1_wdata = $urandom;
        end else begin
            bus.req0_valid = keep_valid; bus.req0_addr = $urandom; bus.req0_wdata = $urandom;
        end
        bus.pready  = 1'($urandom);
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
        got_ctl = {bus.psel, bus.penable, bus.busy, bus.rsp1_valid, bus.rsp0_valid};
        checks++;
        if (got_ctl !== 5'b10100) begin
            failures++;
            $display("FAIL %s setup ctl: got psel,penable,busy,rsp1,rsp0=%b expected 10100", tag, got_ctl);
        end
        got_f = {bus.pwrite, bus.paddr, bus.pwdata};
        checks++;
        if (got_f !== exp_f) begin
            failures++;
            $display("FAIL %s setup fields: got %h expected %h", tag, got_f, exp_f);
        end

        for (int a = 0; a < n_acc; a++) begin
            step();  // ACCESS cycle a
            got_ctl = {bus.psel, bus.penable, bus.busy, bus.rsp1_valid, bus.rsp0_valid};
            checks++;
            if (got_ctl !== 5'b11100 || {bus.req1_gnt, bus.req0_gnt} !== 2'b00) begin
                failures++;
                $display("FAIL %s access%0d ctl: got psel,penable,busy,rsp1,rsp0=%b gnt=%b expected 11100 gnt=00",
                         tag, a, got_ctl, {bus.req1_gnt, bus.req0_gnt});
            end
            got_f = {bus.pwrite, bus.paddr, bus.pwdata};
            checks++;
            if (got_f !== exp_f) begin
                failures++;
                $display("FAIL %s access%0d fields: got %h expected %h", tag, a, got_f, exp_f);
            end
            bus.pready  = (a == waits);
            bus.pslverr = (a == waits) ? slverr : 1'($urandom);
            bus.prdata  = (a == waits) ? rd_val : DW'($urandom);
        end

        step();  // completion cycle
        bus.pready = 1'b0;
        got_ctl = {bus.psel, bus.penable, bus.busy, bus.rsp1_valid, bus.rsp0_valid};
        checks++;
        if (got_ctl !== {3'b000, exp_rsp}) begin
            failures++;
            $display("FAIL %s rsp ctl: got psel,penable,busy,rsp1,rsp0=%b expected %b", tag,
                     got_ctl, {3'b000, exp_rsp});
        end
        checks++;
        if ({bus.rsp_err, bus.rsp_rdata} !== {exp_err, exp_rdata}) begin
            failures++;
            $display("FAIL %s rsp data: got err=%b rdata=%h expected err=%b rdata=%h", tag,
                     bus.rsp_err, bus.rsp_rdata, exp_err, exp_rdata);
        end
        got_f = {bus.pwrite, bus.paddr, bus.pwdata};
        checks++;
        if (got_f !== exp_f) begin
            failures++;
            $display("FAIL %s idle hold: got %h expected %h", tag, got_f, exp_f);
        end
    endtask

    // Drop both requesters; the next cycle must stay idle with no pulse.
    task automatic go_quiet(input string tag);
        logic [5:0] got;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        got = {bus.psel, bus.penable, bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.req0_gnt};
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL %s quiet: got psel,penable,busy,rsp1,rsp0,gnt0=%b expected 000000", tag, got);
        end
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        reset_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 32'h44; bus.req0_wdata = 32'h1;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h88; bus.req1_wdata = 32'h2;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        model_last = 1;
        #3;
        for (int k = 0; k < 2; k++) begin
            ctl = {bus.psel, bus.penable, bus.pwrite, bus.busy, bus.req0_gnt, bus.req1_gnt,
                   bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err};
            checks++;
            if (ctl !== 9'b0 || bus.paddr !== '0 || bus.pwdata !== '0 || bus.rsp_rdata !== '0) begin
                failures++;
                $display("FAIL reset%0d: got ctl=%b paddr=%h pwdata=%h rdata=%h expected all zero",
                         k, ctl, bus.paddr, bus.pwdata, bus.rsp_rdata);
            end
            step();
        end
        reset_n = 1'b1;
        go_quiet("reset_release");
    endtask

    task automatic test_single_write();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1;
        bus.req0_addr  = 32'h0000_0010; bus.req0_wdata = 32'hA5A5_0001;
        run_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, "single_write");
        go_quiet("single_write");
    endtask

    task automatic test_back_to_back();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 32'h100; bus.req0_wdata = $urandom;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h200; bus.req1_wdata = $urandom;
        for (int t = 0; t < 4; t++) run_xfer(0, 1'b0, DW'($urandom), 1'b1, "contention");
        go_quiet("contention");
    endtask

    task automatic test_wait_states();
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h0000_0ABC;
        bus.req1_wdata = $urandom;
        run_xfer(3, 1'b1, 32'h1234_5678, 1'b0, "wait_states");
        go_quiet("wait_states");
    endtask

    task automatic test_timeout();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 32'h0000_0F00;
        bus.req0_wdata = $urandom;
        run_xfer(50, 1'b0, 32'hFFFF_FFFF, 1'b0, "timeout");
        go_quiet("timeout");
    endtask

    task automatic test_reset_in_access();
        logic [6:0] ctl;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 32'h0000_0C00;
        bus.req0_wdata = 32'h5555_AAAA;
        #1;
        step();  // SETUP
        bus.req0_valid = 1'b0;
        bus.pready = 1'b0;
        step();  // ACCESS
        checks++;
        if ({bus.psel, bus.penable} !== 2'b11) begin
            failures++;
            $display("FAIL reset_access pre: got psel,penable=%b expected 11", {bus.psel, bus.penable});
        end
        reset_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            ctl = {bus.psel, bus.penable, bus.busy, bus.rsp0_valid, bus.rsp1_valid,
                   bus.req0_gnt, bus.req1_gnt};
            checks++;
            if (ctl !== 7'b0 || bus.paddr !== '0 || bus.pwdata !== '0) begin
                failures++;
                $display("FAIL reset_access%0d: got ctl=%b paddr=%h pwdata=%h expected zero",
                         k, ctl, bus.paddr, bus.pwdata);
            end
            if (k < 2) step();
        end
        reset_n = 1'b1;
        model_last = 1;
        #1;
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_access release: got rsp0,rsp1=%b expected 00",
                     {bus.rsp0_valid, bus.rsp1_valid});
        end
        run_xfer(0, 1'b0, DW'($urandom), 1'b0, "post_reset");
        go_quiet("post_reset");
    endtask

    task automatic test_random();
        int pat;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) go_quiet("random_gap");
            pat = int'($urandom_range(1, 3));
            bus.req0_valid = pat[0]; bus.req0_write = 1'($urandom);
            bus.req0_addr  = $urandom; bus.req0_wdata = $urandom;
            bus.req1_valid = pat[1]; bus.req1_write = 1'($urandom);
            bus.req1_addr  = $urandom; bus.req1_wdata = $urandom;
            run_xfer(int'($urandom_range(0, 5)), 1'($urandom), DW'($urandom), 1'b0, "random");
        end
        go_quiet("random_end");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_reset_in_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
